// File: rtl/dbus_mem_responder.sv
// Data-bus responder for the multi-cycle core's load/store path.
// Accepts one load or store at a time, holds the core with stall for a
// fixed number of wait states, then completes with a one-cycle ack. Loads
// return sized, sign- or zero-extended data. Stores write a byte-enabled
// word into an internal RAM. Illegal accesses complete with err and have
// no side effect on the RAM.
//
// Handshake: the core raises req together with re or we. It holds all
// request fields until the ack cycle. stall is high from the acceptance
// cycle until the ack cycle, and is low during the ack cycle. A new
// request may be accepted in the cycle after ack.
module dbus_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [2:0]  f3,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        ack,
    output logic        err
);

    localparam int AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam bit SINGLE = (LATENCY == 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dbus_mem_responder: LATENCY must be within 1..15");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic        re_q;
    logic        we_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        go_resp;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [2:0]  cur_f3;
    logic        cur_re;
    logic        cur_we;
    logic [AW-1:0] ram_idx;
    logic        bad_f3;
    logic        misalign;
    logic        oob;
    logic        bad;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] load_val;
    logic [31:0] wr_data;
    logic [3:0]  be;
    logic        do_write;

    assign accept = (state == IDLE) && req && (re || we);
    // Completion happens on the edge into RESP. With a single cycle of
    // latency, that edge is the acceptance edge itself.
    assign go_resp = (SINGLE && accept) || ((state == WAIT) && (cnt == 4'd1));
    assign stall   = rst && (accept || (state == WAIT));

    // In IDLE, the live inputs describe the access. Later, the latched copies do.
    assign cur_addr  = (state == IDLE) ? addr  : addr_q;
    assign cur_wdata = (state == IDLE) ? wdata : wdata_q;
    assign cur_f3    = (state == IDLE) ? f3    : f3_q;
    assign cur_re    = (state == IDLE) ? re    : re_q;
    assign cur_we    = (state == IDLE) ? we    : we_q;
    assign ram_idx   = cur_addr[AW+1:2];

    // Classify the access: illegal size code, misalignment, out-of-range, or conflicting request.
    always_comb begin
        bad_f3 = 1'b0;
        if (cur_re && (cur_f3 == 3'd3 || cur_f3 == 3'd6 || cur_f3 == 3'd7)) bad_f3 = 1'b1;
        if (cur_we && (cur_f3[2] || cur_f3[1:0] == 2'd3)) bad_f3 = 1'b1;
        misalign = ((cur_f3[1:0] == 2'd1) && cur_addr[0]) ||
                   ((cur_f3[1:0] == 2'd2) && (cur_addr[1:0] != 2'd0));
        oob      = {2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS);
        bad      = (cur_re && cur_we) || bad_f3 || misalign || oob;
    end

    // Extract the addressed lane and extend it to 32 bits.
    always_comb begin
        rd_word  = mem[ram_idx];
        rd_shift = rd_word >> {cur_addr[1:0], 3'b000};
        case (cur_f3)
            3'd0:    load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd1:    load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd4:    load_val = {24'd0, rd_shift[7:0]};
            3'd5:    load_val = {16'd0, rd_shift[15:0]};
            default: load_val = rd_word;
        endcase
    end

    // Replicate the store data across lanes and pick the byte enables.
    always_comb begin
        case (cur_f3[1:0])
            2'd0: begin
                wr_data = {4{cur_wdata[7:0]}};
                be      = 4'b0001 << cur_addr[1:0];
            end
            2'd1: begin
                wr_data = {2{cur_wdata[15:0]}};
                be      = cur_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data = cur_wdata;
                be      = 4'b1111;
            end
        endcase
    end

    assign do_write = rst && go_resp && cur_we && !bad;

    // RAM contents are not reset. Only enabled lanes are written.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[ram_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Control FSM with registered ack, err and load data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata   <= 32'd0;
            ack     <= 1'b0;
            err     <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        f3_q    <= f3;
                        re_q    <= re;
                        we_q    <= we;
                        cnt     <= 4'(LATENCY - 1);
                        state   <= SINGLE ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (go_resp) begin
                ack <= 1'b1;
                err <= bad;
                if (cur_re) rdata <= bad ? 32'd0 : load_val;
            end
        end
    end

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Directed bench for dbus_mem_responder with LATENCY=2 and DEPTH_WORDS=1024.
module tb_dbus_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        stall;
    logic        ack;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dbus_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .re(re), .we(we), .addr(addr),
        .f3(f3), .wdata(wdata), .rdata(rdata), .stall(stall), .ack(ack), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete access. Checks latency, stall length, err, optionally rdata, and that ack is a single pulse.
    task automatic access(input string tag, input logic r, input logic w, input logic [31:0] a,
                          input logic [2:0] f, input logic [31:0] d, input logic exp_err,
                          input logic chk_rd, input logic [31:0] exp_rd);
        int n;
        int st;
        bit got;
        @(negedge clk);
        req = 1'b1; re = r; we = w; addr = a; f3 = f; wdata = d;
        n = 0; st = 0; got = 0;
        #1;
        if (stall) st++;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (ack) got = 1;
            else if (stall) st++;
        end
        check({tag, ":latency"}, 32'(n), 32'(LAT));
        check({tag, ":stall_cycles"}, 32'(st), 32'(LAT));
        check({tag, ":stall_at_ack"}, {31'd0, stall}, 32'd0);
        check({tag, ":err"}, {31'd0, err}, {31'd0, exp_err});
        if (chk_rd) check({tag, ":rdata"}, rdata, exp_rd);
        req = 1'b0; re = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check({tag, ":ack_pulse"}, {30'd0, ack, err}, 32'd0);
    endtask

    initial begin
        int n;
        bit got;
        // reset values
        #12;
        check("reset:rdata", rdata, 32'd0);
        check("reset:flags", {29'd0, stall, ack, err}, 32'd0);
        @(negedge clk); rst = 1'b1;

        access("sw_10",  1'b0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0);
        access("lw_10",  1'b1, 1'b0, 32'h10, 3'd2, 32'd0, 1'b0, 1'b1, 32'hDEADBEEF);
        access("sb_11",  1'b0, 1'b1, 32'h11, 3'd0, 32'h0000007F, 1'b0, 1'b1, 32'hDEADBEEF);
        access("lw_10b", 1'b1, 1'b0, 32'h10, 3'd2, 32'd0, 1'b0, 1'b1, 32'hDEAD7FEF);
        access("lb_13",  1'b1, 1'b0, 32'h13, 3'd0, 32'd0, 1'b0, 1'b1, 32'hFFFFFFDE);
        access("lbu_13", 1'b1, 1'b0, 32'h13, 3'd4, 32'd0, 1'b0, 1'b1, 32'h000000DE);
        access("lh_12",  1'b1, 1'b0, 32'h12, 3'd1, 32'd0, 1'b0, 1'b1, 32'hFFFFDEAD);
        access("lhu_12", 1'b1, 1'b0, 32'h12, 3'd5, 32'd0, 1'b0, 1'b1, 32'h0000DEAD);
        access("lb_11",  1'b1, 1'b0, 32'h11, 3'd0, 32'd0, 1'b0, 1'b1, 32'h0000007F);
        access("lh_10",  1'b1, 1'b0, 32'h10, 3'd1, 32'd0, 1'b0, 1'b1, 32'h00007FEF);
        access("sh_12",  1'b0, 1'b1, 32'h12, 3'd1, 32'hFFFF1234, 1'b0, 1'b0, 32'd0);
        access("lw_10c", 1'b1, 1'b0, 32'h10, 3'd2, 32'd0, 1'b0, 1'b1, 32'h12347FEF);
        access("lw_12_mis", 1'b1, 1'b0, 32'h12, 3'd2, 32'd0, 1'b1, 1'b1, 32'd0);

        access("sw_0",   1'b0, 1'b1, 32'h0, 3'd2, 32'h55AA55AA, 1'b0, 1'b0, 32'd0);
        access("lw_0",   1'b1, 1'b0, 32'h0, 3'd2, 32'd0, 1'b0, 1'b1, 32'h55AA55AA);
        access("sw_oob", 1'b0, 1'b1, 32'(4*DEPTH), 3'd2, 32'h01020304, 1'b1, 1'b1, 32'h55AA55AA);
        access("lw_0b",  1'b1, 1'b0, 32'h0, 3'd2, 32'd0, 1'b0, 1'b1, 32'h55AA55AA);
        access("sw_last", 1'b0, 1'b1, 32'(4*DEPTH-4), 3'd2, 32'hA5A5A5A5, 1'b0, 1'b0, 32'd0);
        access("lw_last", 1'b1, 1'b0, 32'(4*DEPTH-4), 3'd2, 32'd0, 1'b0, 1'b1, 32'hA5A5A5A5);
        access("lw_oob", 1'b1, 1'b0, 32'(4*DEPTH), 3'd2, 32'd0, 1'b1, 1'b1, 32'd0);

        access("lh_11_mis", 1'b1, 1'b0, 32'h11, 3'd1, 32'd0, 1'b1, 1'b1, 32'd0);
        access("re_we",     1'b1, 1'b1, 32'h0, 3'd2, 32'h0, 1'b1, 1'b1, 32'd0);
        access("ld_f3_3",   1'b1, 1'b0, 32'h0, 3'd3, 32'd0, 1'b1, 1'b1, 32'd0);
        access("lw_0c",     1'b1, 1'b0, 32'h0, 3'd2, 32'd0, 1'b0, 1'b1, 32'h55AA55AA);
        access("st_f3_4",   1'b0, 1'b1, 32'h0, 3'd4, 32'h0BAD0BAD, 1'b1, 1'b1, 32'h55AA55AA);
        access("lw_0d",     1'b1, 1'b0, 32'h0, 3'd2, 32'd0, 1'b0, 1'b1, 32'h55AA55AA);

        // reset during the wait state of a store
        access("sw_20", 1'b0, 1'b1, 32'h20, 3'd2, 32'h11223344, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        req = 1'b1; we = 1'b1; re = 1'b0; addr = 32'h20; f3 = 3'd2; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("rst_mid:stall_wait", {31'd0, stall}, 32'd1);
        rst = 1'b0; req = 1'b0; we = 1'b0;
        #1;
        check("rst_mid:flags", {29'd0, stall, ack, err}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        access("lw_20", 1'b1, 1'b0, 32'h20, 3'd2, 32'd0, 1'b0, 1'b1, 32'h11223344);

        // back-to-back: req stays high across the ack cycle
        access("sw_14", 1'b0, 1'b1, 32'h14, 3'd2, 32'h0BADC0DE, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        req = 1'b1; re = 1'b1; we = 1'b0; addr = 32'h10; f3 = 3'd2;
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (ack) got = 1;
        end
        check("b2b:first_latency", 32'(n), 32'(LAT));
        check("b2b:first_rdata", rdata, 32'h12347FEF);
        addr = 32'h14;
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (ack) got = 1;
        end
        req = 1'b0; re = 1'b0;
        check("b2b:ack_spacing", 32'(n), 32'(LAT + 1));
        check("b2b:second_rdata", rdata, 32'h0BADC0DE);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
